// File: rtl/cluster_clock_gate_ctrl.sv
// cluster_clock_gate_ctrl: per-domain idle auto-gating with req/ack wake sequencing for cluster clock-gating cells
module cluster_clock_gate_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  input  logic [N_DOMAINS-1:0] cfg_gate_en_i,
  input  logic [N_DOMAINS-1:0] busy_i,
  input  logic [N_DOMAINS-1:0] wake_req_i,
  output logic [N_DOMAINS-1:0] wake_ack_o,
  output logic [N_DOMAINS-1:0] clk_en_o,
  output logic [N_DOMAINS-1:0] gated_o,
  output logic                 all_gated_o
);
  typedef enum logic [1:0] {RUN, IDLE_CNT, OFF, WAKE} state_e;
  state_e               state_q [N_DOMAINS];
  state_e               state_d [N_DOMAINS];
  logic [CNT_W-1:0]     cnt_q   [N_DOMAINS];
  logic [CNT_W-1:0]     cnt_d   [N_DOMAINS];
  logic [N_DOMAINS-1:0] hold;
  logic [N_DOMAINS-1:0] clk_en_q, clk_en_d, ack_q, ack_d, gated_q, gated_d;
  logic                 all_q;
  assign hold = {N_DOMAINS{test_en_i}} | ~cfg_gate_en_i | wake_req_i;
  // per-domain next state, shared idle/wake counter, and next registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = '0;
    gated_d  = '0;
    ack_d    = '0;
    for (int d = 0; d < N_DOMAINS; d++) begin
      case (state_q[d])
        RUN: if (!hold[d] && !busy_i[d]) begin
          state_d[d] = IDLE_CNT;
          cnt_d[d]   = CNT_W'(1);
        end
        IDLE_CNT: if (hold[d] || busy_i[d]) begin
          state_d[d] = RUN;
          cnt_d[d]   = '0;
        end else if (cnt_q[d] == CNT_W'(IDLE_CYCLES - 1)) begin
          state_d[d] = OFF;
          cnt_d[d]   = '0;
        end else begin
          cnt_d[d] = cnt_q[d] + 1'b1;
        end
        OFF: if (hold[d]) begin
          state_d[d] = WAKE;
          cnt_d[d]   = '0;
        end
        WAKE: if (cnt_q[d] == CNT_W'(WAKE_CYCLES - 1)) begin
          state_d[d] = RUN;
          cnt_d[d]   = '0;
        end else begin
          cnt_d[d] = cnt_q[d] + 1'b1;
        end
        default: begin
          state_d[d] = RUN;
          cnt_d[d]   = '0;
        end
      endcase
      clk_en_d[d] = state_d[d] != OFF;
      gated_d[d]  = state_d[d] == OFF;
      ack_d[d]    = wake_req_i[d] & (state_d[d] == RUN);
    end
  end
  // state and output registers; reset forces every domain running with no ack
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int d = 0; d < N_DOMAINS; d++) begin
        state_q[d] <= RUN;
        cnt_q[d]   <= '0;
      end
      clk_en_q <= '1;
      ack_q    <= '0;
      gated_q  <= '0;
      all_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
      gated_q  <= gated_d;
      all_q    <= &gated_d;
    end
  end
  assign clk_en_o    = clk_en_q;
  assign wake_ack_o  = ack_q;
  assign gated_o     = gated_q;
  assign all_gated_o = all_q;
endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// tb_cluster_clock_gate_ctrl: directed stimulus with a run-length behavioural model checked every cycle
module tb_cluster_clock_gate_ctrl;
  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         test_en_i = 1'b0;
  logic [N-1:0] cfg_gate_en_i = '1;
  logic [N-1:0] busy_i = '1;
  logic [N-1:0] wake_req_i = '0;
  logic [N-1:0] wake_ack_o, clk_en_o, gated_o;
  logic         all_gated_o;
  int checks = 0;
  int errors = 0;
  cluster_clock_gate_ctrl #(.N_DOMAINS(N), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(test_en_i), .cfg_gate_en_i(cfg_gate_en_i),
    .busy_i(busy_i), .wake_req_i(wake_req_i), .wake_ack_o(wake_ack_o), .clk_en_o(clk_en_o),
    .gated_o(gated_o), .all_gated_o(all_gated_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  // model: off flag, consecutive idle samples, remaining wake edges
  bit       m_off  [N];
  int       m_idle [N];
  int       m_wake [N];
  logic [N-1:0] e_clk, e_gated, e_ack;
  initial begin
    logic         r, t;
    logic [N-1:0] c, b, q;
    bit           h;
    forever begin
      @(posedge clk_i);
      r = rst_ni; t = test_en_i; c = cfg_gate_en_i; b = busy_i; q = wake_req_i;
      #1;
      for (int d = 0; d < N; d++) begin
        h = t | ~c[d] | q[d];
        if (!r) begin
          m_off[d] = 0; m_idle[d] = 0; m_wake[d] = 0;
        end else if (m_wake[d] > 0) begin
          m_wake[d]--;
        end else if (m_off[d]) begin
          if (h) begin
            m_off[d] = 0;
            m_wake[d] = WAKE;
          end
        end else begin
          m_idle[d] = (h || b[d]) ? 0 : m_idle[d] + 1;
          if (m_idle[d] == IDLE) begin
            m_off[d] = 1;
            m_idle[d] = 0;
          end
        end
        e_clk[d]   = !m_off[d];
        e_gated[d] = m_off[d];
        e_ack[d]   = r && q[d] && !m_off[d] && m_wake[d] == 0;
      end
      check("model clk_en", 32'(clk_en_o), 32'(e_clk));
      check("model gated", 32'(gated_o), 32'(e_gated));
      check("model ack", 32'(wake_ack_o), 32'(e_ack));
      check("model all_gated", 32'(all_gated_o), 32'(&e_gated));
    end
  end
  initial begin
    tick(1);
    check("reset clk_en", 32'(clk_en_o), 32'hF);
    check("reset ack", 32'(wake_ack_o), 32'h0);
    check("reset gated", 32'(gated_o), 32'h0);
    check("reset all", 32'(all_gated_o), 32'h0);
    rst_ni = 1'b1; busy_i = 4'h0;
    tick(15);
    check("idle 15 clk_en", 32'(clk_en_o), 32'hF);
    tick(1);
    check("idle 16 clk_en", 32'(clk_en_o), 32'h0);
    check("idle 16 gated", 32'(gated_o), 32'hF);
    check("idle 16 all", 32'(all_gated_o), 32'h1);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1; busy_i = 4'hE;
    tick(10);
    busy_i = 4'hF;
    tick(3);
    check("abort clk_en", 32'(clk_en_o), 32'hF);
    busy_i = 4'hE;
    tick(15);
    check("restart 15 clk_en", 32'(clk_en_o), 32'hF);
    tick(1);
    check("restart 16 clk_en", 32'(clk_en_o), 32'hE);
    check("restart 16 gated", 32'(gated_o), 32'h1);
    busy_i = 4'b1011;
    tick(16);
    check("d2 off clk_en", 32'(clk_en_o), 32'hA);
    wake_req_i = 4'b0100;
    tick(1);
    check("wake k clk_en", 32'(clk_en_o), 32'hE);
    check("wake k ack", 32'(wake_ack_o), 32'h0);
    tick(1);
    check("wake k+1 ack", 32'(wake_ack_o), 32'h0);
    tick(1);
    check("wake k+2 ack", 32'(wake_ack_o), 32'h4);
    wake_req_i = 4'h0;
    tick(1);
    check("wake k+3 ack", 32'(wake_ack_o), 32'h0);
    tick(14);
    check("regate early clk_en", 32'(clk_en_o), 32'hE);
    tick(1);
    check("regate clk_en", 32'(clk_en_o), 32'hA);
    wake_req_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("run wake ack", 32'(wake_ack_o), 32'h2);
      check("run wake clk_en", 32'(clk_en_o), 32'hA);
    end
    wake_req_i = 4'h0;
    tick(1);
    check("run wake ack drop", 32'(wake_ack_o), 32'h0);
    busy_i = 4'h0;
    tick(16);
    check("all off", 32'(all_gated_o), 32'h1);
    test_en_i = 1'b1;
    tick(1);
    check("test clk_en", 32'(clk_en_o), 32'hF);
    check("test gated", 32'(gated_o), 32'h0);
    tick(40);
    check("test hold clk_en", 32'(clk_en_o), 32'hF);
    test_en_i = 1'b0; cfg_gate_en_i = 4'b1110;
    tick(15);
    check("cfg 15 clk_en", 32'(clk_en_o), 32'hF);
    tick(1);
    check("cfg 16 clk_en", 32'(clk_en_o), 32'h1);
    cfg_gate_en_i = 4'hF;
    tick(16);
    check("all off again", 32'(clk_en_o), 32'h0);
    wake_req_i = 4'b1000;
    tick(2);
    check("d3 waking clk_en", 32'(clk_en_o), 32'h8);
    rst_ni = 1'b0;
    tick(1);
    check("midrst clk_en", 32'(clk_en_o), 32'hF);
    check("midrst ack", 32'(wake_ack_o), 32'h0);
    check("midrst gated", 32'(gated_o), 32'h0);
    check("midrst all", 32'(all_gated_o), 32'h0);
    rst_ni = 1'b1; wake_req_i = 4'h0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
